// File: rtl/regfile_wb.sv
// Writeback-side 32 x WIDTH register file with two combinational read ports; X31 reads as zero.
// Optional macro REGFILE_BYPASS_EN forwards the in-flight write to matching read ports.
module regfile_wb #(
    parameter int WIDTH = 64,
    parameter int NREG  = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2,
    output logic [31:0]      wr_onehot
);

    logic [WIDTH-1:0] r_regs [0:NREG-2];
    logic [31:0]      r_wr_onehot;

    logic [3:0]       w_grp_en;
    logic [31:0]      w_dec;
    logic [31:0]      w_wen;
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;

    // 2:4 group select on the top address bits, gated by the write strobe
    always_comb begin
        w_grp_en = 4'b0000;
        if (RegWrite) begin
            w_grp_en = 4'b0001 << WriteRegister[4:3];
        end
    end

    // 3:8 decode inside each group; X31 enable is forced off
    always_comb begin
        w_dec = 32'h0;
        for (int g = 0; g < 4; g++) begin
            if (w_grp_en[g]) begin
                w_dec[g*8 +: 8] = 8'b0000_0001 << WriteRegister[2:0];
            end
        end
        w_wen = {1'b0, w_dec[30:0]};
    end

    // Storage update and debug copy of the write enable
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG-1; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_onehot <= 32'h0;
        end else begin
            for (int i = 0; i < NREG-1; i++) begin
                if (w_wen[i]) begin
                    r_regs[i] <= WriteData;
                end
            end
            r_wr_onehot <= w_wen;
        end
    end

    // Stored-value read muxes; address 31 matches no entry and yields zero
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        for (int i = 0; i < NREG-1; i++) begin
            if (ReadRegister1 == 5'(i)) begin
                w_rd1 = r_regs[i];
            end
            if (ReadRegister2 == 5'(i)) begin
                w_rd2 = r_regs[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_fwd_ok;

    // Forward the writeback value to any port reading the register being written
    always_comb begin
        w_fwd_ok  = RegWrite && (WriteRegister != 5'd31);
        ReadData1 = w_rd1;
        ReadData2 = w_rd2;
        if (w_fwd_ok && (WriteRegister == ReadRegister1)) begin
            ReadData1 = WriteData;
        end
        if (w_fwd_ok && (WriteRegister == ReadRegister2)) begin
            ReadData2 = WriteData;
        end
    end
`else
    // No forwarding: ports show the stored value until the write edge
    always_comb begin
        ReadData1 = w_rd1;
        ReadData2 = w_rd2;
    end
`endif

    assign wr_onehot = r_wr_onehot;

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: vector table, model-backed scoreboard
// and directed reset / hazard / sweep sequences.
module tb_regfile_wb;

    localparam int W = 64;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         RegWrite;
    logic [4:0]   WriteRegister;
    logic [W-1:0] WriteData;
    logic [4:0]   ReadRegister1;
    logic [4:0]   ReadRegister2;
    logic [W-1:0] ReadData1;
    logic [W-1:0] ReadData2;
    logic [31:0]  wr_onehot;

    regfile_wb #(.WIDTH(W), .NREG(32)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .wr_onehot     (wr_onehot)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           we;
        logic [4:0]   wr;
        logic [W-1:0] wd;
        logic [4:0]   r1;
        logic [4:0]   r2;
        logic [W-1:0] e1;
        logic [W-1:0] e2;
        logic [31:0]  eoh;
    } vec_t;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] m_regs [0:31];
    logic [W-1:0] sb_q [$];
    vec_t         vecs [9];

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_sb(string nm, logic [W-1:0] act);
        logic [W-1:0] e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got %h expected <scoreboard empty>", nm, act);
        end else begin
            e = sb_q.pop_front();
            chk(nm, act, e);
        end
    endtask

    function automatic logic [W-1:0] exp_pre(logic [4:0] a);
        if (a == 5'd31) return '0;
        if (BYP && RegWrite && WriteRegister != 5'd31 && WriteRegister == a)
            return WriteData;
        return m_regs[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
    endtask

    // One cycle: drive, check pre-edge reads, clock, check wr_onehot
    task automatic step(bit we, logic [4:0] wr, logic [W-1:0] wd,
                        logic [4:0] r1, logic [4:0] r2);
        logic [31:0] eoh;
        @(negedge clk);
        RegWrite      = we;
        WriteRegister = wr;
        WriteData     = wd;
        ReadRegister1 = r1;
        ReadRegister2 = r2;
        #1;
        sb_q.push_back(exp_pre(r1));
        sb_q.push_back(exp_pre(r2));
        chk_sb("pre_rd1", ReadData1);
        chk_sb("pre_rd2", ReadData2);
        @(posedge clk);
        #1;
        eoh = 32'h0;
        if (we && wr != 5'd31) begin
            m_regs[wr] = wd;
            eoh = 32'h1 << wr;
        end
        chk("onehot", {32'h0, wr_onehot}, {32'h0, eoh});
    endtask

    initial begin
        vecs[0] = '{1, 5'd7,  64'hDEADBEEF_00000007, 5'd7,  5'd31,
                    64'hDEADBEEF_00000007, 64'h0, 32'h0000_0080};
        vecs[1] = '{1, 5'd31, 64'hFFFFFFFF_FFFFFFFF, 5'd7,  5'd31,
                    64'hDEADBEEF_00000007, 64'h0, 32'h0};
        vecs[2] = '{0, 5'd9,  64'h55,                5'd9,  5'd7,
                    64'h0, 64'hDEADBEEF_00000007, 32'h0};
        vecs[3] = '{1, 5'd0,  64'h1111,              5'd0,  5'd9,
                    64'h1111, 64'h0, 32'h0000_0001};
        vecs[4] = '{1, 5'd30, 64'hA5A5,              5'd30, 5'd0,
                    64'hA5A5, 64'h1111, 32'h4000_0000};
        vecs[5] = '{1, 5'd30, 64'h5A5A,              5'd30, 5'd30,
                    64'h5A5A, 64'h5A5A, 32'h4000_0000};
        vecs[6] = '{1, 5'd8,  64'h88,                5'd8,  5'd7,
                    64'h88, 64'hDEADBEEF_00000007, 32'h0000_0100};
        vecs[7] = '{1, 5'd23, 64'h23,                5'd23, 5'd24,
                    64'h23, 64'h0, 32'h0080_0000};
        vecs[8] = '{1, 5'd24, 64'h24,                5'd24, 5'd23,
                    64'h24, 64'h23, 32'h0100_0000};

        // Reset state
        reset_n       = 1'b0;
        RegWrite      = 1'b0;
        WriteRegister = 5'd0;
        WriteData     = '0;
        ReadRegister1 = 5'd0;
        ReadRegister2 = 5'd30;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_onehot", {32'h0, wr_onehot}, 64'h0);
        chk("rst_rd1", ReadData1, 64'h0);
        chk("rst_rd2", ReadData2, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Vector table
        foreach (vecs[k]) begin
            step(vecs[k].we, vecs[k].wr, vecs[k].wd, vecs[k].r1, vecs[k].r2);
            chk($sformatf("vec%0d_rd1", k), ReadData1, vecs[k].e1);
            chk($sformatf("vec%0d_rd2", k), ReadData2, vecs[k].e2);
            chk($sformatf("vec%0d_oh", k), {32'h0, wr_onehot}, {32'h0, vecs[k].eoh});
        end

        // Sweep all writable registers
        for (int i = 0; i < 31; i++) begin
            step(1'b1, 5'(i), 64'(i * 32'h0101), 5'd31, 5'(i));
            chk($sformatf("sweep_oh%0d", i), {32'h0, wr_onehot},
                {32'h0, 32'h1 << i});
        end
        for (int i = 0; i < 31; i++) begin
            step(1'b0, 5'd0, '0, 5'(i), 5'(30 - i));
            chk($sformatf("sweep_rd1_%0d", i), ReadData1, 64'(i * 32'h0101));
            chk($sformatf("sweep_rd2_%0d", i), ReadData2,
                64'((30 - i) * 32'h0101));
        end

        // Same-cycle write/read hazard on X3
        step(1'b1, 5'd3, 64'hAA, 5'd3, 5'd31);
        @(negedge clk);
        RegWrite      = 1'b1;
        WriteRegister = 5'd3;
        WriteData     = 64'hBB;
        ReadRegister1 = 5'd3;
        ReadRegister2 = 5'd3;
        #1;
        chk("haz_pre_rd1", ReadData1, BYP ? 64'hBB : 64'hAA);
        @(posedge clk);
        #1;
        m_regs[3] = 64'hBB;
        chk("haz_post_rd1", ReadData1, 64'hBB);
        chk("haz_post_rd2", ReadData2, 64'hBB);

        // X31 write with X31 read in the same cycle
        step(1'b1, 5'd31, 64'hFFFFFFFF_FFFFFFFF, 5'd31, 5'd3);
        chk("x31_rd1", ReadData1, 64'h0);
        chk("x31_rd2", ReadData2, 64'hBB);

        // Reset mid-stream discards the in-flight write
        step(1'b1, 5'd5, 64'h1234, 5'd5, 5'd6);
        chk("rst_seq_x5", ReadData1, 64'h1234);
        @(negedge clk);
        reset_n       = 1'b0;
        RegWrite      = 1'b1;
        WriteRegister = 5'd6;
        WriteData     = 64'h66;
        @(negedge clk);
        RegWrite = 1'b0;
        @(posedge clk);
        #1;
        model_clear();
        chk("rst_seq_rd1", ReadData1, 64'h0);
        chk("rst_seq_oh", {32'h0, wr_onehot}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_seq_x6", ReadData2, 64'h0);
        step(1'b0, 5'd6, 64'h66, 5'd6, 5'd3);
        chk("rst_seq_x3", ReadData2, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
